// File: rtl/aes_bridge_pkg.sv
// Shared types and helpers for the Wishbone -> dmem bridge in front of the AES
// register block.
//  - dmem_width_e   : dmem transfer width code (byte/half/word)
//  - RESP_*         : dmem response codes
//  - bridge_state_e : bridge FSM states
//  - sel_decode     : WB byte-lane select -> {legal, width, offset}
//  - wr_align       : WB-lane write data -> right-justified dmem write data
//  - rd_align       : right-justified dmem read data -> WB-lane read data
package aes_bridge_pkg;

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10
    } dmem_width_e;

    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_ACK,
        ST_ERR,
        ST_DRAIN
    } bridge_state_e;

    typedef struct packed {
        logic        legal;
        dmem_width_e width;
        logic [1:0]  off;
    } sel_dec_t;

    // Only naturally aligned single byte, half and word selects are legal.
    function automatic sel_dec_t sel_decode(input logic [3:0] sel);
        sel_dec_t d;
        d.legal = 1'b1;
        d.width = W_BYTE;
        d.off   = 2'd0;
        case (sel)
            4'b0001: d.off = 2'd0;
            4'b0010: d.off = 2'd1;
            4'b0100: d.off = 2'd2;
            4'b1000: d.off = 2'd3;
            4'b0011: d.width = W_HALF;
            4'b1100: begin d.width = W_HALF; d.off = 2'd2; end
            4'b1111: d.width = W_WORD;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // Shift the selected lanes down to bit 0 and zero everything above the width.
    function automatic logic [31:0] wr_align(input dmem_width_e w, input logic [1:0] off,
                                             input logic [31:0] dat);
        logic [31:0] s;
        s = dat >> {off, 3'b000};
        case (w)
            W_BYTE:  return {24'h0, s[7:0]};
            W_HALF:  return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Place right-justified read data back on its WB lanes; other lanes read 0.
    function automatic logic [31:0] rd_align(input dmem_width_e w, input logic [1:0] off,
                                             input logic [31:0] dat);
        case (w)
            W_BYTE:  return {24'h0, dat[7:0]}  << {off, 3'b000};
            W_HALF:  return {16'h0, dat[15:0]} << {off, 3'b000};
            default: return dat;
        endcase
    endfunction

endpackage

// File: rtl/aes_wb_dmem_bridge.sv
// Wishbone B4 classic slave to dmem req/ack/resp master. Each WB cycle becomes
// exactly one dmem transfer (or an immediate error for an unsupported byte
// select). A timeout keeps an absent or hung dmem target from stalling the bus.
// Ports:
//  mclk, rst_n                      clock, async active-low reset
//  wbs_cyc_i/stb_i/we_i/adr_i/sel_i/dat_i   WB request
//  wbs_dat_o/ack_o/err_o            WB response (ack/err one-cycle pulses)
//  dmem_req/cmd/width/addr/wdata    dmem request, held until dmem_req_ack
//  dmem_req_ack, dmem_rdata, dmem_resp      dmem handshake and response
module aes_wb_dmem_bridge
    import aes_bridge_pkg::*;
#(
    parameter int unsigned TMO_CYC = 256,
    parameter int unsigned TMO_W   = 9
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [6:0]  wbs_adr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        dmem_req,
    output logic        dmem_cmd,
    output logic [1:0]  dmem_width,
    output logic [6:0]  dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_req_ack,
    input  logic [31:0] dmem_rdata,
    input  logic [1:0]  dmem_resp
);

    bridge_state_e     state;
    dmem_width_e       width_q;
    logic [1:0]        off_q;
    logic [TMO_W-1:0]  tmo_cnt;
    sel_dec_t          dec;
    logic              tmo_hit;
    logic              resp_any;
    logic              resp_ok;
    logic              unused_adr;

    assign dec        = sel_decode(wbs_sel_i);
    assign dmem_width = width_q;
    assign resp_any   = (dmem_resp != RESP_NONE);
    assign resp_ok    = (dmem_resp == RESP_OK);
    // Counter is 0 in the first request cycle, so the last allowed cycle is TMO_CYC-1.
    assign tmo_hit    = (TMO_CYC != 0) && (tmo_cnt == TMO_W'(TMO_CYC - 1));
    // Byte offset is taken from sel, never from the low address bits.
    assign unused_adr = ^wbs_adr_i[1:0];

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            width_q    <= W_BYTE;
            off_q      <= 2'd0;
            tmo_cnt    <= '0;
            wbs_dat_o  <= 32'h0;
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_cmd   <= 1'b0;
            dmem_addr  <= 7'h0;
            dmem_wdata <= 32'h0;
        end else begin
            // Terminations are single-cycle pulses.
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        if (dec.legal) begin
                            dmem_req   <= 1'b1;
                            dmem_cmd   <= wbs_we_i;
                            width_q    <= dec.width;
                            off_q      <= dec.off;
                            dmem_addr  <= {wbs_adr_i[6:2], dec.off};
                            dmem_wdata <= wr_align(dec.width, dec.off, wbs_dat_i);
                            tmo_cnt    <= '0;
                            state      <= ST_REQ;
                        end else begin
                            wbs_err_o <= 1'b1;
                            state     <= ST_ERR;
                        end
                    end
                end
                ST_REQ: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (!wbs_cyc_i) begin
                        // Master gave up before acceptance: nothing to terminate.
                        dmem_req <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (dmem_req_ack && resp_any) begin
                        // Target answered in the accept cycle.
                        dmem_req <= 1'b0;
                        if (resp_ok) begin
                            if (!dmem_cmd) wbs_dat_o <= rd_align(width_q, off_q, dmem_rdata);
                            wbs_ack_o <= 1'b1;
                            state     <= ST_ACK;
                        end else begin
                            wbs_err_o <= 1'b1;
                            state     <= ST_ERR;
                        end
                    end else if (tmo_hit) begin
                        dmem_req  <= 1'b0;
                        wbs_err_o <= 1'b1;
                        state     <= ST_ERR;
                    end else if (dmem_req_ack) begin
                        dmem_req <= 1'b0;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (!wbs_cyc_i) begin
                        // Target still owes a response; absorb it silently.
                        state <= resp_any ? ST_IDLE : ST_DRAIN;
                    end else if (resp_ok) begin
                        if (!dmem_cmd) wbs_dat_o <= rd_align(width_q, off_q, dmem_rdata);
                        wbs_ack_o <= 1'b1;
                        state     <= ST_ACK;
                    end else if (resp_any || tmo_hit) begin
                        wbs_err_o <= 1'b1;
                        state     <= ST_ERR;
                    end
                end
                ST_DRAIN: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (resp_any || tmo_hit) state <= ST_IDLE;
                end
                ST_ACK:  state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_wb_dmem_bridge.sv
module tb_aes_wb_dmem_bridge;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [6:0]  wbs_adr_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o;
    logic        dmem_req, dmem_cmd;
    logic [1:0]  dmem_width;
    logic [6:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;

    int errors = 0;
    int checks = 0;

    aes_wb_dmem_bridge #(.TMO_CYC(16), .TMO_W(9)) dut (
        .mclk(mclk), .rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    always #5 mclk = ~mclk;

    // Responder modelled on the AES register block: req_ack one cycle after
    // req is seen, response rsp_delay cycles after req_ack. Drives on negedge.
    logic        rsp_en = 1'b0;
    int          rsp_delay = 1;
    logic [1:0]  rsp_code = 2'b01;
    logic [31:0] rsp_data = 32'h0;
    int          rsp_st = 0;
    int          rsp_cnt = 0;

    always @(negedge mclk) begin
        dmem_req_ack = 1'b0;
        dmem_resp    = 2'b00;
        if (!rst_n) begin
            rsp_st = 0;
        end else if (rsp_en) begin
            case (rsp_st)
                0: if (dmem_req) rsp_st = 1;
                1: begin dmem_req_ack = 1'b1; rsp_cnt = rsp_delay; rsp_st = 2; end
                2: begin
                    rsp_cnt = rsp_cnt - 1;
                    if (rsp_cnt == 0) begin
                        dmem_resp  = rsp_code;
                        dmem_rdata = rsp_data;
                        rsp_st     = 0;
                    end
                end
                default: rsp_st = 0;
            endcase
        end
    end

    // Results of the last wb_xfer call.
    int          x_lat, x_reqcyc;
    logic        x_ack, x_err, x_req, x_both;
    logic        cap_cmd;
    logic [1:0]  cap_width;
    logic [6:0]  cap_addr;
    logic [31:0] cap_wdata;

    // One WB access. Latency counts posedges from stb assertion to the first
    // sample (1 time unit after an edge) showing ack or err; bounded at 40.
    task automatic wb_xfer(input logic we, input logic [6:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
        @(posedge mclk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
        x_lat = -1; x_reqcyc = 0; x_ack = 1'b0; x_err = 1'b0; x_req = 1'b0; x_both = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge mclk); #1;
            if (dmem_req) begin
                if (!x_req) begin
                    cap_cmd = dmem_cmd; cap_width = dmem_width;
                    cap_addr = dmem_addr; cap_wdata = dmem_wdata;
                end
                x_req = 1'b1;
                x_reqcyc++;
            end
            if (wbs_ack_o && wbs_err_o) x_both = 1'b1;
            if (wbs_ack_o || wbs_err_o) begin
                x_ack = wbs_ack_o; x_err = wbs_err_o; x_lat = n;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = 0; wbs_sel_i = 0; wbs_dat_i = 0;
        dmem_req_ack = 0; dmem_rdata = 0; dmem_resp = 0;
        repeat (3) @(posedge mclk);
        #1;
        checks++;
        if ({wbs_ack_o, wbs_err_o, dmem_req, dmem_cmd} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ack/err/req/cmd=%b want 0000",
                     {wbs_ack_o, wbs_err_o, dmem_req, dmem_cmd});
        end
        checks++;
        if ({wbs_dat_o, dmem_width, dmem_addr, dmem_wdata} !== 73'h0) begin
            errors++;
            $display("FAIL reset_data: got dat_o=%h width=%b addr=%h wdata=%h want all 0",
                     wbs_dat_o, dmem_width, dmem_addr, dmem_wdata);
        end
        rst_n  = 1'b1;
        rsp_en = 1'b1;
    endtask

    task automatic test_word_write();
        rsp_delay = 1; rsp_code = 2'b01;
        wb_xfer(1'b1, 7'h04, 4'b1111, 32'h11223344);
        checks++;
        if (!(x_ack === 1'b1 && x_err === 1'b0 && x_lat == 4 && !x_both)) begin
            errors++;
            $display("FAIL word_wr_term: got ack=%b err=%b lat=%0d want ack=1 err=0 lat=4",
                     x_ack, x_err, x_lat);
        end
        checks++;
        if ({cap_cmd, cap_width, cap_addr, cap_wdata} !== {1'b1, 2'b10, 7'h04, 32'h11223344}) begin
            errors++;
            $display("FAIL word_wr_fields: got cmd=%b width=%b addr=%h wdata=%h want 1 10 04 11223344",
                     cap_cmd, cap_width, cap_addr, cap_wdata);
        end
        checks++;
        if (wbs_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL word_wr_dat_o: got %h want 00000000", wbs_dat_o);
        end
    endtask

    task automatic test_byte_read();
        rsp_data = 32'h000000AB;
        wb_xfer(1'b0, 7'h08, 4'b0100, 32'hFFFFFFFF);
        checks++;
        if (!(x_ack === 1'b1 && x_err === 1'b0 && x_lat == 4)) begin
            errors++;
            $display("FAIL byte_rd_term: got ack=%b err=%b lat=%0d want 1 0 4", x_ack, x_err, x_lat);
        end
        checks++;
        if ({cap_cmd, cap_width, cap_addr} !== {1'b0, 2'b00, 7'h0A}) begin
            errors++;
            $display("FAIL byte_rd_fields: got cmd=%b width=%b addr=%h want 0 00 0a",
                     cap_cmd, cap_width, cap_addr);
        end
        checks++;
        if (wbs_dat_o !== 32'h00AB0000) begin
            errors++;
            $display("FAIL byte_rd_data: got %h want 00ab0000", wbs_dat_o);
        end
    endtask

    task automatic test_half_access();
        wb_xfer(1'b1, 7'h10, 4'b1100, 32'hBEEF0000);
        checks++;
        if (!(x_ack === 1'b1 && x_err === 1'b0)) begin
            errors++;
            $display("FAIL half_wr_term: got ack=%b err=%b want 1 0", x_ack, x_err);
        end
        checks++;
        if ({cap_width, cap_addr, cap_wdata} !== {2'b01, 7'h12, 32'h0000BEEF}) begin
            errors++;
            $display("FAIL half_wr_fields: got width=%b addr=%h wdata=%h want 01 12 0000beef",
                     cap_width, cap_addr, cap_wdata);
        end
        checks++;
        if (wbs_dat_o !== 32'h00AB0000) begin
            errors++;
            $display("FAIL half_wr_dat_hold: got %h want 00ab0000", wbs_dat_o);
        end
        rsp_data = 32'h1234CAFE;
        wb_xfer(1'b0, 7'h44, 4'b0011, 32'h0);
        checks++;
        if ({x_ack, cap_width, cap_addr, wbs_dat_o} !== {1'b1, 2'b01, 7'h44, 32'h0000CAFE}) begin
            errors++;
            $display("FAIL half_rd: got ack=%b width=%b addr=%h dat_o=%h want 1 01 44 0000cafe",
                     x_ack, cap_width, cap_addr, wbs_dat_o);
        end
    endtask

    task automatic test_resp_error();
        rsp_code = 2'b11; rsp_data = 32'hDEADBEEF;
        wb_xfer(1'b0, 7'h0C, 4'b1111, 32'h0);
        checks++;
        if (!(x_ack === 1'b0 && x_err === 1'b1 && x_lat == 4 && wbs_dat_o === 32'h0000CAFE)) begin
            errors++;
            $display("FAIL resp_err: got ack=%b err=%b lat=%0d dat_o=%h want 0 1 4 0000cafe",
                     x_ack, x_err, x_lat, wbs_dat_o);
        end
        rsp_code = 2'b01;
    endtask

    task automatic test_illegal_sel();
        wb_xfer(1'b1, 7'h04, 4'b0101, 32'h12345678);
        checks++;
        if (!(x_err === 1'b1 && x_ack === 1'b0 && x_req === 1'b0 && x_lat == 1)) begin
            errors++;
            $display("FAIL illegal_0101: got err=%b ack=%b req_seen=%b lat=%0d want 1 0 0 1",
                     x_err, x_ack, x_req, x_lat);
        end
        wb_xfer(1'b0, 7'h04, 4'b0000, 32'h0);
        checks++;
        if (!(x_err === 1'b1 && x_ack === 1'b0 && x_req === 1'b0 && x_lat == 1)) begin
            errors++;
            $display("FAIL illegal_0000: got err=%b ack=%b req_seen=%b lat=%0d want 1 0 0 1",
                     x_err, x_ack, x_req, x_lat);
        end
    endtask

    task automatic test_timeout();
        rsp_en = 1'b0;
        wb_xfer(1'b1, 7'h20, 4'b1111, 32'hCAFEF00D);
        checks++;
        if (!(x_err === 1'b1 && x_ack === 1'b0 && x_reqcyc == 16 && dmem_req === 1'b0)) begin
            errors++;
            $display("FAIL timeout: got err=%b ack=%b req_cycles=%0d req=%b want 1 0 16 0",
                     x_err, x_ack, x_reqcyc, dmem_req);
        end
        @(posedge mclk); #1;
        checks++;
        if (wbs_err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_once: got err=%b want 0", wbs_err_o);
        end
        rsp_en = 1'b1;
        wb_xfer(1'b1, 7'h24, 4'b1111, 32'h0BADF00D);
        checks++;
        if (!(x_ack === 1'b1 && x_err === 1'b0 && x_lat == 4 && cap_wdata === 32'h0BADF00D)) begin
            errors++;
            $display("FAIL after_timeout: got ack=%b err=%b lat=%0d wdata=%h want 1 0 4 0badf00d",
                     x_ack, x_err, x_lat, cap_wdata);
        end
    endtask

    task automatic test_drain();
        logic seen_ack, seen_term;
        rsp_delay = 3;
        seen_ack = 1'b0; seen_term = 1'b0;
        @(posedge mclk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 7'h30; wbs_sel_i = 4'b1111; wbs_dat_i = 32'h55AA55AA;
        for (int n = 0; n < 10; n++) begin
            @(posedge mclk); #1;
            if (dmem_req_ack) begin seen_ack = 1'b1; break; end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge mclk); #1;
            if (wbs_ack_o || wbs_err_o) seen_term = 1'b1;
        end
        checks++;
        if (!(seen_ack === 1'b1 && seen_term === 1'b0)) begin
            errors++;
            $display("FAIL drain: got req_ack_seen=%b termination=%b want 1 0", seen_ack, seen_term);
        end
        rsp_delay = 1;
        wb_xfer(1'b1, 7'h34, 4'b0001, 32'h000000C3);
        checks++;
        if (!(x_ack === 1'b1 && x_err === 1'b0 && x_lat == 4 && cap_wdata === 32'h000000C3)) begin
            errors++;
            $display("FAIL after_drain: got ack=%b err=%b lat=%0d wdata=%h want 1 0 4 000000c3",
                     x_ack, x_err, x_lat, cap_wdata);
        end
    endtask

    task automatic test_reset_mid_req();
        logic req_up;
        rsp_en = 1'b0;
        @(posedge mclk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 7'h08; wbs_sel_i = 4'b1111; wbs_dat_i = 32'h01020304;
        @(posedge mclk); #1;
        @(posedge mclk); #1;
        req_up = dmem_req;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!(req_up === 1'b1 && dmem_req === 1'b0 && wbs_ack_o === 1'b0 && wbs_err_o === 1'b0
              && dmem_wdata === 32'h0)) begin
            errors++;
            $display("FAIL reset_mid_req: got req_before=%b req=%b ack=%b err=%b wdata=%h want 1 0 0 0 0",
                     req_up, dmem_req, wbs_ack_o, wbs_err_o, dmem_wdata);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge mclk); #1;
        rst_n  = 1'b1;
        rsp_en = 1'b1;
        wb_xfer(1'b1, 7'h08, 4'b1111, 32'hA5A5A5A5);
        checks++;
        if (!(x_ack === 1'b1 && x_err === 1'b0 && x_lat == 4)) begin
            errors++;
            $display("FAIL after_reset: got ack=%b err=%b lat=%0d want 1 0 4", x_ack, x_err, x_lat);
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_read();
        test_half_access();
        test_resp_error();
        test_illegal_sel();
        test_timeout();
        test_drain();
        test_reset_mid_req();
        repeat (2) @(posedge mclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
